// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage -- single-clock LEGv8 decode stage with a registered
// ID/EX output bank.
//
// Holds the main control decode, a NUM_REGS-entry register file (the top entry
// is XZR: it reads 0 and ignores writes) and the immediate sign-extender. The
// register file is written on the rising edge. A read of the register being
// written in the same cycle returns the new data.
//
// Optional feature, macro PIPELINED_DECODE_HAZARD_EN:
//   When defined, a load in ID/EX whose destination is a source of the
//   incoming instruction raises hazard_stall and one bubble is inserted.
//   When undefined, hazard_stall is tied 0.
//
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   if_valid, instruction instruction from IF/ID
//   id_flush              squash the instruction entering ID/EX
//   wb_en/addr/data       write-back port
//   hazard_stall          combinational; fetch holds PC and IF/ID
//   ex_valid .. alu_op    registered ID/EX decode and control
//   read_data1/2          registered R[Rn], R[reg2]
module pipelined_decode_stage #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_valid,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 id_flush,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [WORD-1:0]      wb_data,
  output logic                 hazard_stall,
  output logic                 ex_valid,
  output logic [10:0]          opcode,
  output logic [4:0]           rd,
  output logic [WORD-1:0]      sign_ext_imm,
  output logic                 reg2_loc,
  output logic                 uncondbranch,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic [1:0]           alu_op,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2
);

  localparam logic [4:0]  XZR     = 5'(NUM_REGS - 1);
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  typedef struct packed {
    logic       reg2_loc;
    logic       uncondbranch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [10:0]     op;
  logic [4:0]      rn, reg2;
  ctrl_t           dec_ctrl, ex_ctrl;
  logic [WORD-1:0] dec_imm, rdata1, rdata2;
  logic            load;
  logic [WORD-1:0] regs [NUM_REGS];

  assign op = instruction[31:21];
  assign rn = instruction[9:5];

  // Main control and immediate selection
  always_comb begin
    dec_ctrl = '0;
    dec_imm  = '0;
    casez (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      OP_LDUR: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      end
      OP_STUR: begin
        dec_ctrl.reg2_loc  = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_imm = {{(WORD-9){instruction[20]}}, instruction[20:12]};
      end
      11'b10110100???: begin  // CBZ
        dec_ctrl.reg2_loc = 1'b1;
        dec_ctrl.branch   = 1'b1;
        dec_ctrl.alu_op   = 2'b01;
        dec_imm = {{(WORD-19){instruction[23]}}, instruction[23:5]};
      end
      11'b000101?????: begin  // B
        dec_ctrl.uncondbranch = 1'b1;
        dec_imm = {{(WORD-26){instruction[25]}}, instruction[25:0]};
      end
      default: ;
    endcase
  end

  assign reg2 = dec_ctrl.reg2_loc ? instruction[4:0] : instruction[20:16];

  // Read ports: XZR first, then same-cycle write-back bypass, then the array
  assign rdata1 = (rn == XZR) ? '0 : (wb_en && wb_addr == rn) ? wb_data : regs[rn];
  assign rdata2 = (reg2 == XZR) ? '0 : (wb_en && wb_addr == reg2) ? wb_data : regs[reg2];

`ifdef PIPELINED_DECODE_HAZARD_EN
  logic reads_reg2;
  always_comb begin
    reads_reg2 = 1'b0;
    casez (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_STUR, 11'b10110100???: reads_reg2 = 1'b1;
      default: ;
    endcase
  end
  // Flush wins: a squashed instruction cannot need a stall
  assign hazard_stall = if_valid & ~id_flush & ex_valid & ex_ctrl.mem_read & (rd != XZR) &
                        ((rd == rn) | (reads_reg2 & (rd == reg2)));
`else
  assign hazard_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != XZR) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Flush, stall and invalid input all produce an all-zero bubble
  assign load = if_valid & ~id_flush & ~hazard_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      opcode       <= '0;
      rd           <= '0;
      sign_ext_imm <= '0;
      read_data1   <= '0;
      read_data2   <= '0;
    end else if (!load) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      opcode       <= '0;
      rd           <= '0;
      sign_ext_imm <= '0;
      read_data1   <= '0;
      read_data2   <= '0;
    end else begin
      ex_valid     <= 1'b1;
      ex_ctrl      <= dec_ctrl;
      opcode       <= op;
      rd           <= instruction[4:0];
      sign_ext_imm <= dec_imm;
      read_data1   <= rdata1;
      read_data2   <= rdata2;
    end
  end

  assign reg2_loc     = ex_ctrl.reg2_loc;
  assign uncondbranch = ex_ctrl.uncondbranch;
  assign branch       = ex_ctrl.branch;
  assign mem_read     = ex_ctrl.mem_read;
  assign mem_to_reg   = ex_ctrl.mem_to_reg;
  assign mem_write    = ex_ctrl.mem_write;
  assign alu_src      = ex_ctrl.alu_src;
  assign reg_write    = ex_ctrl.reg_write;
  assign alu_op       = ex_ctrl.alu_op;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Bench for pipelined_decode_stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference model (class table, array
// register file, arithmetic sign extension).
module tb_pipelined_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0, id_flush = 1'b0, wb_en = 1'b0;
  logic [31:0] instruction = '0;
  logic [4:0]  wb_addr = '0;
  logic [63:0] wb_data = '0;
  logic        hazard_stall, ex_valid, reg2_loc, uncondbranch, branch, mem_read;
  logic        mem_to_reg, mem_write, alu_src, reg_write;
  logic [10:0] opcode;
  logic [4:0]  rd;
  logic [1:0]  alu_op;
  logic [63:0] sign_ext_imm, read_data1, read_data2;
  logic [9:0]  a_ctrl;

  int checks = 0, errors = 0;

`ifdef PIPELINED_DECODE_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  always #5 clk = ~clk;

  pipelined_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instruction(instruction),
    .id_flush(id_flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .opcode(opcode), .rd(rd),
    .sign_ext_imm(sign_ext_imm), .reg2_loc(reg2_loc), .uncondbranch(uncondbranch),
    .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .alu_op(alu_op), .read_data1(read_data1), .read_data2(read_data2));

  assign a_ctrl = {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg,
                   mem_write, alu_src, reg_write, alu_op};

  // ---------------- reference model ----------------
  // ctrl vector: {reg2_loc, uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
  localparam logic [9:0] C_R    = 10'b00000001_10;
  localparam logic [9:0] C_LDUR = 10'b00011011_00;
  localparam logic [9:0] C_STUR = 10'b10000110_00;
  localparam logic [9:0] C_CBZ  = 10'b10100000_01;
  localparam logic [9:0] C_B    = 10'b01000000_00;

  logic [63:0] m_regs [32];
  logic        e_valid, e_stall, a_stall;
  logic [10:0] e_op;
  logic [4:0]  e_rd;
  logic [9:0]  e_ctrl;
  logic [63:0] e_imm, e_rd1, e_rd2;

  // 0 unmatched, 1 R-type, 2 LDUR, 3 STUR, 4 CBZ, 5 B
  function automatic int iclass(input logic [31:0] i);
    logic [10:0] o;
    o = i[31:21];
    if (o == 11'h458 || o == 11'h658 || o == 11'h450 || o == 11'h550) return 1;
    if (o == 11'h7C2) return 2;
    if (o == 11'h7C0) return 3;
    if (i[31:24] == 8'hB4) return 4;
    if (i[31:26] == 6'h05) return 5;
    return 0;
  endfunction

  function automatic logic [9:0] ctrl_of(input int c);
    case (c)
      1: return C_R;
      2: return C_LDUR;
      3: return C_STUR;
      4: return C_CBZ;
      5: return C_B;
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic [63:0] imm_of(input int c, input logic [31:0] i);
    longint f;
    f = 0;
    case (c)
      2, 3: begin f = longint'(i[20:12]); if (f >= 256) f -= 512; end
      4:    begin f = longint'(i[23:5]);  if (f >= (64'sd1 << 18)) f -= (64'sd1 << 19); end
      5:    begin f = longint'(i[25:0]);  if (f >= (64'sd1 << 25)) f -= (64'sd1 << 26); end
      default: f = 0;
    endcase
    return 64'(f);
  endfunction

  function automatic logic [63:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [63:0] wd);
    if (a == 5'd31) return 64'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    e_valid = 0; e_stall = 0; e_op = 0; e_rd = 0; e_ctrl = 0;
    e_imm = 0; e_rd1 = 0; e_rd2 = 0;
  endtask

  // Called at a negedge: drives inputs, samples hazard_stall, clocks, updates model.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [63:0] wd);
    int c;
    logic [4:0] rn, r2;
    logic uses2;
    if_valid = v; instruction = ins; id_flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    c = iclass(ins);
    rn = ins[9:5];
    r2 = (c == 3 || c == 4) ? ins[4:0] : ins[20:16];
    uses2 = (c == 1 || c == 3 || c == 4);
    e_stall = HZ && v && !fl && e_valid && e_ctrl[6] && e_rd != 5'd31 &&
              (e_rd == rn || (uses2 && e_rd == r2));
    #1 a_stall = hazard_stall;
    @(posedge clk);
    if (!v || fl || e_stall) begin
      e_valid = 0; e_op = 0; e_rd = 0; e_ctrl = 0; e_imm = 0; e_rd1 = 0; e_rd2 = 0;
    end else begin
      e_valid = 1; e_op = ins[31:21]; e_rd = ins[4:0]; e_ctrl = ctrl_of(c);
      e_imm = imm_of(c, ins); e_rd1 = mread(rn, we, wa, wd); e_rd2 = mread(r2, we, wa, wd);
    end
    if (we && wa != 5'd31) m_regs[wa] = wd;
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [10:0] rop;
    a = pick_reg(); b = pick_reg(); c = pick_reg();
    case ($urandom_range(0, 5))
      0: begin
        case ($urandom_range(0, 3))
          0: rop = 11'h458; 1: rop = 11'h658; 2: rop = 11'h450; default: rop = 11'h550;
        endcase
        return {rop, b, 6'($urandom), a, c};
      end
      1: return {11'h7C2, 9'($urandom), 2'b00, a, c};
      2: return {11'h7C0, 9'($urandom), 2'b00, a, c};
      3: return {8'hB4, 19'($urandom), c};
      4: return {6'h05, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  localparam logic [31:0] LDUR_X9  = 32'hF84402C9;              // LDUR X9,[X22,#64]
  localparam logic [31:0] ADD_X10  = {11'h458, 5'd9, 6'd0, 5'd19, 5'd10};
  localparam logic [31:0] ADD_XZR  = {11'h458, 5'd31, 6'd0, 5'd31, 5'd1};
  localparam logic [31:0] ADD_X5   = {11'h458, 5'd5, 6'd0, 5'd5, 5'd0};
  localparam logic [31:0] STUR_X1  = {11'h7C0, 9'd8, 2'b00, 5'd2, 5'd1};
  localparam logic [31:0] CBZ_M5   = {8'hB4, 19'h7FFFB, 5'd11};
  localparam logic [31:0] B_M55    = {6'h05, 26'h3FFFFC9};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; model_clear();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ex_valid, a_ctrl, opcode, rd} !== '0 || sign_ext_imm !== 64'd0 ||
        read_data1 !== 64'd0 || read_data2 !== 64'd0) begin
      errors++; $display("FAIL reset_init got v=%b ctrl=%b op=%h", ex_valid, a_ctrl, opcode);
    end
    rst_n = 1;
    // Load state, then reset in the middle of a cycle
    step(1, LDUR_X9, 0, 1, 5'd5, 64'd123);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({ex_valid, a_ctrl, opcode, rd} !== '0 || sign_ext_imm !== 64'd0 ||
        read_data1 !== 64'd0 || read_data2 !== 64'd0) begin
      errors++; $display("FAIL reset_async got v=%b ctrl=%b op=%h imm=%h", ex_valid, a_ctrl, opcode, sign_ext_imm);
    end
    model_clear();
    @(negedge clk); rst_n = 1;
    step(1, ADD_X5, 0, 0, 5'd0, 64'd0);
    checks++;
    if (read_data1 !== 64'd0 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL reset_x5 got rd1=%h v=%b exp 0 1", read_data1, ex_valid);
    end
  endtask

  task automatic test_ldur();
    step(0, 32'd0, 0, 1, 5'd22, 64'd16);
    step(1, LDUR_X9, 0, 0, 5'd0, 64'd0);
    checks++;
    if (opcode !== 11'b11111000010 || rd !== 5'd9) begin
      errors++; $display("FAIL ldur_op got op=%b rd=%0d", opcode, rd);
    end
    checks++;
    if (sign_ext_imm !== 64'h40 || read_data1 !== 64'd16) begin
      errors++; $display("FAIL ldur_data got imm=%h rd1=%h exp 40 10", sign_ext_imm, read_data1);
    end
    checks++;
    if (a_ctrl !== C_LDUR || ex_valid !== 1'b1) begin
      errors++; $display("FAIL ldur_ctrl got %b exp %b", a_ctrl, C_LDUR);
    end
  endtask

  task automatic test_bypass();
    step(0, 32'd0, 0, 0, 5'd0, 64'd0);
    step(1, ADD_X10, 0, 1, 5'd9, 64'd20);
    checks++;
    if (read_data2 !== 64'd20 || a_ctrl !== C_R || ex_valid !== 1'b1) begin
      errors++; $display("FAIL bypass got rd2=%h ctrl=%b exp 20 %b", read_data2, a_ctrl, C_R);
    end
    step(1, ADD_X10, 0, 0, 5'd0, 64'd0);
    checks++;
    if (read_data2 !== 64'd20) begin
      errors++; $display("FAIL bypass_commit got rd2=%h exp 20", read_data2);
    end
    step(1, ADD_XZR, 0, 1, 5'd31, 64'd77);
    checks++;
    if (read_data1 !== 64'd0 || read_data2 !== 64'd0) begin
      errors++; $display("FAIL xzr_bypass got %h %h exp 0", read_data1, read_data2);
    end
    step(1, ADD_XZR, 0, 0, 5'd0, 64'd0);
    checks++;
    if (read_data1 !== 64'd0) begin
      errors++; $display("FAIL xzr_write got %h exp 0", read_data1);
    end
  endtask

  task automatic test_imm();
    step(1, CBZ_M5, 0, 0, 5'd0, 64'd0);
    checks++;
    if (sign_ext_imm !== 64'hFFFF_FFFF_FFFF_FFFB || a_ctrl !== C_CBZ) begin
      errors++; $display("FAIL cbz got imm=%h ctrl=%b", sign_ext_imm, a_ctrl);
    end
    step(1, B_M55, 0, 0, 5'd0, 64'd0);
    checks++;
    if (sign_ext_imm !== 64'hFFFF_FFFF_FFFF_FFC9 || a_ctrl !== C_B) begin
      errors++; $display("FAIL b got imm=%h ctrl=%b", sign_ext_imm, a_ctrl);
    end
  endtask

  task automatic test_hazard();
    step(0, 32'd0, 0, 0, 5'd0, 64'd0);
    step(1, LDUR_X9, 0, 0, 5'd0, 64'd0);
    step(1, ADD_X10, 0, 0, 5'd0, 64'd0);
`ifdef PIPELINED_DECODE_HAZARD_EN
    checks++;
    if (a_stall !== 1'b1 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL hz_stall got stall=%b v=%b exp 1 0", a_stall, ex_valid);
    end
    step(1, ADD_X10, 0, 0, 5'd0, 64'd0);
`endif
    checks++;
    if (a_stall !== 1'b0 || ex_valid !== 1'b1 || opcode !== 11'h458) begin
      errors++; $display("FAIL hz_add got stall=%b v=%b op=%h", a_stall, ex_valid, opcode);
    end
    // Flush on the same edge overrides the stall
    step(1, LDUR_X9, 0, 0, 5'd0, 64'd0);
    step(1, ADD_X10, 1, 0, 5'd0, 64'd0);
    checks++;
    if (a_stall !== 1'b0 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL hz_flush got stall=%b v=%b exp 0 0", a_stall, ex_valid);
    end
  endtask

  task automatic test_flush();
    step(1, STUR_X1, 1, 0, 5'd0, 64'd0);
    checks++;
    if (ex_valid !== 1'b0 || mem_write !== 1'b0 || a_ctrl !== 10'd0) begin
      errors++; $display("FAIL flush got v=%b mw=%b ctrl=%b", ex_valid, mem_write, a_ctrl);
    end
    step(1, STUR_X1, 0, 0, 5'd0, 64'd0);
    checks++;
    if (ex_valid !== 1'b1 || a_ctrl !== C_STUR || sign_ext_imm !== 64'd8 || rd !== 5'd1) begin
      errors++; $display("FAIL after_flush got v=%b ctrl=%b imm=%h", ex_valid, a_ctrl, sign_ext_imm);
    end
  endtask

  task automatic test_random();
    logic v, fl, we;
    logic [31:0] ins;
    logic [4:0] wa;
    v = 0; ins = 0;
    for (int n = 0; n < 400; n++) begin
      if (!e_stall) begin
        v = ($urandom_range(0, 99) < 88);
        ins = rand_instr();
      end
      fl = ($urandom_range(0, 99) < 8);
      we = 1'($urandom_range(0, 1));
      wa = pick_reg();
      step(v, ins, fl, we, wa, {$urandom, $urandom});
      checks++;
      if (a_stall !== e_stall) begin
        errors++; $display("FAIL rand_stall n=%0d got %b exp %b ins=%h", n, a_stall, e_stall, ins);
      end
      checks++;
      if (ex_valid !== e_valid || opcode !== e_op || rd !== e_rd || a_ctrl !== e_ctrl) begin
        errors++;
        $display("FAIL rand_ctrl n=%0d got v=%b op=%h rd=%0d c=%b exp v=%b op=%h rd=%0d c=%b",
                 n, ex_valid, opcode, rd, a_ctrl, e_valid, e_op, e_rd, e_ctrl);
      end
      checks++;
      if (sign_ext_imm !== e_imm || read_data1 !== e_rd1 || read_data2 !== e_rd2) begin
        errors++;
        $display("FAIL rand_data n=%0d got imm=%h r1=%h r2=%h exp imm=%h r1=%h r2=%h",
                 n, sign_ext_imm, read_data1, read_data2, e_imm, e_rd1, e_rd2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldur();
    test_bypass();
    test_imm();
    test_hazard();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
